// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Reusable by uart_tx.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;
    localparam int DATA_BITS  = 8;
    localparam int IDX_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Fractional phase-accumulator producing 16x-baud oversample ticks; i_clr
// realigns the phase to a start edge.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [32:0] INC = 33'(OVERSAMPLE * baud);
    localparam logic [32:0] LIM = 33'(clk_freq);

    logic [31:0] r_acc;
    logic        r_tick;
    logic [32:0] w_sum;

    // One spare bit so the add cannot wrap before the compare.
    assign w_sum  = {1'b0, r_acc} + INC;
    assign o_tick = r_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (w_sum >= LIM) begin
            r_acc  <= 32'(w_sum - LIM);
            r_tick <= 1'b1;
        end else begin
            r_acc  <= w_sum[31:0];
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 LSB first, majority vote at mid-bit.
// Define UART_RX_PARITY_EN for 8E1 with a parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [3:0]       T_PRE    = 4'(SAMPLE_MID - 1);
    localparam logic [3:0]       T_MID    = 4'(SAMPLE_MID);
    localparam logic [3:0]       T_POST   = 4'(SAMPLE_MID + 1);

    rx_state_t              r_state, w_next;
    logic [1:0]             r_sync;
    logic [3:0]             r_tcnt;
    logic                   r_s7, r_s8;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [7:0]             r_data;
    logic                   r_valid, r_ferr;
    logic                   w_rxs, w_tick, w_at9, w_vote, w_deliver, w_ferr_set;
    logic [3:0]             w_tnum;

    assign w_rxs  = r_sync[1];
    // Tick numbering starts at 1 after the start edge, so ticks 7..9 straddle mid-bit.
    assign w_tnum = r_tcnt + 4'd1;
    assign w_at9  = w_tick && (w_tnum == T_POST);
    assign w_vote = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

    uart_rx_tick_gen #(
        .clk_freq (clk_freq),
        .baud     (baud)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_deliver  = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            IDLE:  if (!w_rxs) w_next = START;
            START: if (w_at9) w_next = w_vote ? IDLE : DATA;
            DATA: begin
                if (w_at9 && r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_at9) w_next = STOP;
`endif
            STOP: begin
                if (w_at9) begin
                    if (w_vote) begin
                        w_next    = IDLE;
                        w_deliver = 1'b1;
                    end else begin
                        w_next     = BREAK;
                        w_ferr_set = 1'b1;
                    end
                end
            end
            BREAK:   if (w_rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_tcnt  <= '0;
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_valid <= w_deliver;
            r_ferr  <= w_ferr_set;
            if (r_state == IDLE)  r_tcnt <= '0;
            else if (w_tick)      r_tcnt <= w_tnum;
            if (w_tick && w_tnum == T_PRE) r_s7 <= w_rxs;
            if (w_tick && w_tnum == T_MID) r_s8 <= w_rxs;
            if (r_state == START) r_idx <= '0;
            if (r_state == DATA && w_at9) begin
                r_shift[r_idx] <= w_vote;
                r_idx          <= r_idx + 1'b1;
            end
            if (w_deliver) r_data <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_perr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_state == PARITY && w_at9) r_par <= w_vote;
            r_perr <= w_deliver && (r_par != ^r_shift);
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level expectation queue is checked every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int  CLK_FREQ = 12000000;
  localparam int  BAUD     = 115200;
  localparam real CLK_HALF = 1.0e9 / CLK_FREQ / 2.0;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  uart_rx #(.clk_freq(CLK_FREQ), .baud(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err));

  always #(CLK_HALF) clk = ~clk;

  typedef struct packed {logic is_ferr; logic perr; logic [7:0] data;} ev_t;
  ev_t        exp_q[$];
  logic [7:0] m_last = 8'h00;
  int         checks = 0, passed = 0;
  int         cyc = 0, start_cyc = 0, valid_cyc = 0;
  logic       rst_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Transmitter model: queues the outcome the frame must produce, then drives the line.
  task automatic send(input logic [7:0] d, input real bt, input logic stop_v, input logic perr_inj);
    ev_t e;
    e.is_ferr = ~stop_v;
    e.perr    = perr_inj;
    e.data    = d;
    exp_q.push_back(e);
    start_cyc = cyc;
    rx = 1'b0; #(bt);
    for (int i = 0; i < 8; i++) begin rx = d[i]; #(bt); end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ perr_inj; #(bt);
`endif
    rx = stop_v; #(bt);
    if (!stop_v) #(3.0 * bt);
    rx = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  always @(negedge clk) begin
    if (!rst_q) begin
      m_last <= 8'h00;
      chk("reset_data", 32'(rx_data), 32'h0);
      chk("reset_flags", 32'({rx_valid, frame_err, parity_err, rx_busy}), 32'h0);
    end else if (rx_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'({rx_valid, frame_err}), 32'h0);
        chk("rx_data_hold", 32'(rx_data), 32'(m_last));
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_ferr) begin
          chk("ferr_strobe", 32'({rx_valid, frame_err, parity_err}), 32'b010);
          chk("ferr_data_kept", 32'(rx_data), 32'(m_last));
        end else begin
          chk("valid_strobe", 32'({rx_valid, frame_err, parity_err}), 32'({2'b10, e.perr}));
          chk("valid_data", 32'(rx_data), 32'(e.data));
          chk("busy_at_valid", 32'(rx_busy), 32'h0);
          m_last    <= e.data;
          valid_cyc <= cyc;
        end
      end
    end else begin
      chk("quiet_perr", 32'(parity_err), 32'h0);
      chk("rx_data_hold", 32'(rx_data), 32'(m_last));
    end
  end

  initial begin
    int lat;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(8'hA5, BIT_NS, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    lat = valid_cyc - start_cyc;
    chk("latency_A5_in_996_1006", 32'(lat >= 996 && lat <= 1006), 32'h1);
    chk("lit_data_A5", 32'(rx_data), 32'hA5);
    chk("lit_busy_idle", 32'(rx_busy), 32'h0);

    send(8'h00, BIT_NS / 1.03, 1'b1, 1'b0);
    send(8'hFF, BIT_NS / 1.03, 1'b1, 1'b0);
    send(8'h55, BIT_NS / 1.03, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("lit_fast_last", 32'(rx_data), 32'h55);
    send(8'h00, BIT_NS / 0.97, 1'b1, 1'b0);
    send(8'hFF, BIT_NS / 0.97, 1'b1, 1'b0);
    send(8'h55, BIT_NS / 0.97, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("lit_slow_last", 32'(rx_data), 32'h55);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy_high", 32'(rx_busy), 32'h1);
    repeat (110) @(negedge clk);
    chk("glitch_busy_low", 32'(rx_busy), 32'h0);

    send(8'h3C, BIT_NS, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    chk("lit_ferr_kept", 32'(rx_data), 32'h55);
    chk("break_released", 32'(rx_busy), 32'h0);
    send(8'h81, BIT_NS, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("lit_after_break", 32'(rx_data), 32'h81);

    rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 4; i++) begin rx = 1'(8'h7E >> i); #(BIT_NS); end
    rx = 1'b1; #(BIT_NS / 2.0);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_data", 32'(rx_data), 32'h0);
    chk("lit_reset_busy", 32'(rx_busy), 32'h0);
    repeat (300) @(negedge clk);
    send(8'h42, BIT_NS, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("lit_after_reset", 32'(rx_data), 32'h42);

`ifdef UART_RX_PARITY_EN
    send(8'h07, BIT_NS, 1'b1, 1'b0);
    send(8'h07, BIT_NS, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    chk("lit_parity_data", 32'(rx_data), 32'h07);
`endif

    repeat (300) @(negedge clk);
    chk("all_expected_seen", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
